// File: rtl/sample_sequencer_if.sv
// Handshake bundle between the sample sequencer and the codec/effect blocks.
// master: drives adc_req, proc_start, dac_load; slave: drives adc_ack, proc_done.
interface sample_sequencer_if;
    logic adc_req;
    logic adc_ack;
    logic proc_start;
    logic proc_done;
    logic dac_load;

    modport master (
        output adc_req,
        output proc_start,
        output dac_load,
        input  adc_ack,
        input  proc_done
    );

    modport slave (
        input  adc_req,
        input  proc_start,
        input  dac_load,
        output adc_ack,
        output proc_done
    );
endinterface

// File: rtl/sample_sequencer.sv
// Frame-level sample sequencer: divides clk into frames and steps one sample
// through ADC capture, effect processing and DAC load, flagging overruns.
// Ports:
//   clk, rst         system clock, async active-high reset
//   i_en             run enable (low holds counter at 0, FSM in IDLE)
//   i_div            clocks per frame minus 1, latched at frame boundaries
//   i_clr_overrun    clears the sticky overrun flag
//   bus (master)     adc_req/adc_ack, proc_start/proc_done, dac_load
//   o_sample_tick    one-cycle pulse at the start of a sequenced frame
//   o_overrun        sticky frame-overrun flag
//   o_state          debug state (IDLE=0 WAIT=1 CAPTURE=2 PROCESS=3 OUTPUT=4)
//   o_count          current frame counter value
module sample_sequencer #(
    parameter int DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_clr_overrun,
    sample_sequencer_if.master   bus,
    output logic                 o_sample_tick,
    output logic                 o_overrun,
    output logic [2:0]           o_state,
    output logic [DIV_WIDTH-1:0] o_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PROCESS = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] r_div_q;
    logic                 r_tick;
    logic                 r_adc_req;
    logic                 r_proc_start;
    logic                 r_dac_load;
    logic                 r_overrun;
    logic                 w_wrap;
    logic                 w_boundary;
    logic                 w_busy;
    logic                 w_tick;
    logic                 w_adc_req;
    logic                 w_proc_start;
    logic                 w_dac_load;
    logic                 w_overrun;

    assign w_wrap     = (r_count == r_div_q);
    assign w_boundary = i_en && w_wrap;

    // A sample is in flight in any of the three active states.
    assign w_busy = (r_state == ST_CAPTURE) ||
                    (r_state == ST_PROCESS) ||
                    (r_state == ST_OUTPUT);

    // Frame counter; the divider is only sampled while stopped or at a
    // boundary so a new div never truncates or stretches a running frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_div_q <= '0;
        end else if (!i_en) begin
            r_count <= '0;
            r_div_q <= i_div;
        end else if (w_wrap) begin
            r_count <= '0;
            r_div_q <= i_div;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Next state and the registered strobes derived from it.
    always_comb begin
        w_next       = r_state;
        w_tick       = 1'b0;
        w_adc_req    = 1'b0;
        w_proc_start = 1'b0;
        w_dac_load   = 1'b0;
        w_overrun    = r_overrun;

        if (!i_en) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (w_boundary) begin
                        w_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.adc_ack) begin
                        w_next = ST_PROCESS;
                    end
                end
                ST_PROCESS: begin
                    if (bus.proc_done) begin
                        w_next = ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    w_next = ST_WAIT;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end

        // Only a boundary that actually launches a sample produces a tick.
        w_tick       = w_boundary && !w_busy;
        w_adc_req    = (w_next == ST_CAPTURE);
        w_proc_start = (w_next == ST_PROCESS) && (r_state != ST_PROCESS);
        w_dac_load   = (w_next == ST_OUTPUT);

        // Setting takes priority so an overrun is never lost to a clear.
        if (w_boundary && w_busy) begin
            w_overrun = 1'b1;
        end else if (i_clr_overrun) begin
            w_overrun = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tick       <= 1'b0;
            r_adc_req    <= 1'b0;
            r_proc_start <= 1'b0;
            r_dac_load   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tick       <= w_tick;
            r_adc_req    <= w_adc_req;
            r_proc_start <= w_proc_start;
            r_dac_load   <= w_dac_load;
            r_overrun    <= w_overrun;
        end
    end

    assign bus.adc_req    = r_adc_req;
    assign bus.proc_start = r_proc_start;
    assign bus.dac_load   = r_dac_load;
    assign o_sample_tick  = r_tick;
    assign o_overrun      = r_overrun;
    assign o_state        = r_state;
    assign o_count        = r_count;

endmodule
